// File: rtl/jtframe_scan2x_pkg.sv
// Shared types, defaults and sizing helpers for the line-doubling scan converter.
// Imported by the interface, the line-buffer RAM and the top module.
package jtframe_scan2x_pkg;

    localparam int COLORW_DEF = 4;

    // Which replay of the stored line is on the output
    typedef enum logic {
        PASS_FIRST  = 1'b0,
        PASS_SECOND = 1'b1
    } pass_e;

    // Width of one {R,G,B} pixel word
    function automatic int pxl_w(input int colorw);
        return 3 * colorw;
    endfunction

    // Line-buffer address: in-line offset plus the bank bit as MSB
    function automatic int addr_w(input int hlen);
        return $clog2(hlen) + 1;
    endfunction

endpackage

// File: rtl/jtframe_scan2x_if.sv
// Video bundle between the colour mixer side and the doubled-rate output side.
// master: drives pxl_cen, pxl2_cen, base_pxl, HS; reads x2_pxl, x2_HS. slave: the converter.
interface jtframe_scan2x_if
    import jtframe_scan2x_pkg::*;
#(
    parameter int COLORW = COLORW_DEF
);
    localparam int PW = pxl_w(COLORW);

    logic          pxl_cen;
    logic          pxl2_cen;
    logic [PW-1:0] base_pxl;
    logic          HS;
    logic [PW-1:0] x2_pxl;
    logic          x2_HS;

    modport master (
        output pxl_cen, pxl2_cen, base_pxl, HS,
        input  x2_pxl, x2_HS
    );

    modport slave (
        input  pxl_cen, pxl2_cen, base_pxl, HS,
        output x2_pxl, x2_HS
    );

endinterface

// File: rtl/jtframe_scan2x_dpram.sv
// Ping-pong line buffer: 2*HLEN words, one write port, one registered read port.
// Ports: clk_i, we_i, waddr_i/raddr_i ({bank, offset}), wdata_i, rdata_o.
module jtframe_scan2x_dpram
    import jtframe_scan2x_pkg::*;
#(
    parameter int DW   = pxl_w(COLORW_DEF),
    parameter int HLEN = 396,
    parameter int AW   = addr_w(HLEN)
)(
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [0:2*HLEN-1];
    logic [DW-1:0] rdata_q;
    logic [AW-1:0] widx;
    logic [AW-1:0] ridx;

    // Bank 1 is packed right after bank 0 so the array holds exactly 2*HLEN words
    function automatic logic [AW-1:0] lin(input logic [AW-1:0] a);
        return {1'b0, a[AW-2:0]} + (a[AW-1] ? AW'(HLEN) : '0);
    endfunction

    assign widx = lin(waddr_i);
    assign ridx = lin(raddr_i);

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[widx] <= wdata_i;
        end
        rdata_q <= mem_q[ridx];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/jtframe_scan2x_dbl.sv
// Line doubler: stores each input line at pxl_cen and replays it twice at pxl2_cen.
// Ports: clk, rst_n (async, active low), vid (slave: pxl_cen, pxl2_cen, base_pxl, HS,
// x2_pxl, x2_HS). Optional JTFRAME_SCAN2X_SCANLINE_EN halves intensity on the second pass.
module jtframe_scan2x_dbl
    import jtframe_scan2x_pkg::*;
#(
    parameter int COLORW   = COLORW_DEF,
    parameter int HLEN     = 396,
    parameter int HS_PULSE = 32
)(
    input  logic            clk,
    input  logic            rst_n,
    jtframe_scan2x_if.slave vid
);

    localparam int PW = pxl_w(COLORW);
    localparam int AW = addr_w(HLEN);
    localparam int RW = AW - 1;

    localparam logic [RW-1:0] LAST = RW'(HLEN - 1);
    localparam logic [RW-1:0] HSW  = RW'(HS_PULSE);

    logic          hs_l_q, hs_l_d;
    logic          wbank_q, wbank_d;
    logic [RW-1:0] waddr_q, waddr_d;
    logic [RW-1:0] raddr_q, raddr_d;
    pass_e         pass_q, pass_d;
    logic [PW-1:0] x2_pxl_q, x2_pxl_d;
    logic          x2_hs_q, x2_hs_d;

    logic          line_start;
    logic          wsel_bank;
    logic [RW-1:0] wsel_addr;
    logic [PW-1:0] rdata;
    logic [PW-1:0] shaded;

    assign line_start = vid.pxl_cen & vid.HS & ~hs_l_q;

    // A line start takes precedence over the normal write: that pixel
    // lands at offset 0 of the freshly selected bank.
    always_comb begin
        wsel_bank = line_start ? ~wbank_q : wbank_q;
        wsel_addr = line_start ? '0 : waddr_q;
        hs_l_d    = hs_l_q;
        wbank_d   = wbank_q;
        waddr_d   = waddr_q;
        if (vid.pxl_cen) begin
            hs_l_d  = vid.HS;
            wbank_d = wsel_bank;
            // Saturate: overlong lines keep overwriting the last word
            waddr_d = (wsel_addr == LAST) ? wsel_addr
                                          : wsel_addr + RW'(1);
        end
    end

    always_comb begin
        raddr_d = raddr_q;
        pass_d  = pass_q;
        if (line_start) begin
            raddr_d = '0;
            pass_d  = PASS_FIRST;
        end else if (vid.pxl2_cen) begin
            if (raddr_q == LAST) begin
                raddr_d = '0;
                pass_d  = (pass_q == PASS_FIRST) ? PASS_SECOND
                                                 : PASS_FIRST;
            end else begin
                raddr_d = raddr_q + RW'(1);
            end
        end
    end

    jtframe_scan2x_dpram #(
        .DW   (PW),
        .HLEN (HLEN),
        .AW   (AW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (vid.pxl_cen & rst_n),
        .waddr_i ({wsel_bank, wsel_addr}),
        .wdata_i (vid.base_pxl),
        .raddr_i ({~wbank_q, raddr_q}),
        .rdata_o (rdata)
    );

    // pass_q still describes the address whose data sits in rdata
    always_comb begin
        shaded = rdata;
`ifdef JTFRAME_SCAN2X_SCANLINE_EN
        if (pass_q == PASS_SECOND) begin
            for (int c = 0; c < 3; c++) begin
                shaded[c*COLORW +: COLORW] = rdata[c*COLORW +: COLORW] >> 1;
            end
        end
`endif
    end

    always_comb begin
        x2_pxl_d = x2_pxl_q;
        x2_hs_d  = x2_hs_q;
        if (vid.pxl2_cen) begin
            x2_pxl_d = shaded;
            x2_hs_d  = (raddr_q < HSW);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_l_q   <= 1'b0;
            wbank_q  <= 1'b0;
            waddr_q  <= '0;
            raddr_q  <= '0;
            pass_q   <= PASS_FIRST;
            x2_pxl_q <= '0;
            x2_hs_q  <= 1'b0;
        end else begin
            hs_l_q   <= hs_l_d;
            wbank_q  <= wbank_d;
            waddr_q  <= waddr_d;
            raddr_q  <= raddr_d;
            pass_q   <= pass_d;
            x2_pxl_q <= x2_pxl_d;
            x2_hs_q  <= x2_hs_d;
        end
    end

    assign vid.x2_pxl = x2_pxl_q;
    assign vid.x2_HS  = x2_hs_q;

endmodule

// File: tb/tb_jtframe_scan2x_dbl.sv
// Directed bench for jtframe_scan2x_dbl: a table of input lines (length, reset
// point, pixel source, expected x2_HS statistics) plus per-tick output checks.
`timescale 1ns/1ps
module tb_jtframe_scan2x_dbl;
    import jtframe_scan2x_pkg::*;

    localparam int COLORW   = 4;
    localparam int HLEN     = 396;
    localparam int HS_PULSE = 32;
    localparam int NL       = 9;

    typedef struct {
        int npix;
        int rst_at;
        bit cpix;
        int exp_rises;
        int exp_width;
    } line_vec_t;

    line_vec_t tbl [NL];

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    jtframe_scan2x_if #(.COLORW(COLORW)) vid();

    jtframe_scan2x_dbl #(
        .COLORW   (COLORW),
        .HLEN     (HLEN),
        .HS_PULSE (HS_PULSE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vid   (vid)
    );

    always #10 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [11:0] mem_m [2][HLEN];
    bit          val_m [2][HLEN];
    bit          wbank_m = 0;
    bit          hs_l_m = 0;
    int          waddr_m = 0;
    bit          rbank = 0;
    int          j = -1;
    bit          last_p2 = 0;
    bit          last_ls = 0;
    bit          prev_hs = 0;
    int          rises = 0;
    int          wcur = 0;
    int          wmax = 0;
    int          cur_line = 0;
    logic [11:0] lfsr = 12'hAAA;
    logic [11:0] long_last = '0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (line %0d tick %0d)",
                     name, act, exp, cur_line, j);
        end
    endtask

    function automatic logic [11:0] half(input logic [11:0] p);
        return {1'b0, p[11:9], 1'b0, p[7:5], 1'b0, p[3:1]};
    endfunction

    task automatic sample_tick();
        int idx;
        logic [11:0] e;
        if (last_ls) begin
            j = 0;
            rbank = !wbank_m;
        end else if (j >= 0) begin
            j++;
            idx = (j - 1) % HLEN;
            chk("x2_HS", int'(vid.x2_HS), int'(idx < HS_PULSE));
            if (val_m[rbank][idx]) begin
                e = mem_m[rbank][idx];
`ifdef JTFRAME_SCAN2X_SCANLINE_EN
                if (((j - 1) / HLEN) % 2 == 1) e = half(e);
`endif
                chk("x2_pxl", int'(vid.x2_pxl), int'(e));
            end
            if (cur_line == 7 && j == HLEN)
                chk("long_tail", int'(vid.x2_pxl), int'(long_last));
            if (cur_line == 8 && j == 10)
                chk("const_pass1", int'(vid.x2_pxl), 'hAAA);
            if (cur_line == 8 && j == HLEN + 10) begin
`ifdef JTFRAME_SCAN2X_SCANLINE_EN
                chk("const_pass2", int'(vid.x2_pxl), 'h555);
`else
                chk("const_pass2", int'(vid.x2_pxl), 'hAAA);
`endif
            end
        end
        if (j >= 1 && vid.x2_HS && !prev_hs) rises++;
        if (vid.x2_HS) wcur++;
        else wcur = 0;
        if (wcur > wmax) wmax = wcur;
        prev_hs = vid.x2_HS;
    endtask

    task automatic step_sample();
        @(negedge clk);
        if (last_p2 && rst_n) sample_tick();
    endtask

    task automatic drive(input bit pc, input bit p2c,
                         input logic [11:0] px, input bit hs);
        bit ls;
        vid.pxl_cen  = pc;
        vid.pxl2_cen = p2c;
        vid.base_pxl = px;
        vid.HS       = hs;
        last_ls = 0;
        if (pc && rst_n) begin
            ls = hs && !hs_l_m;
            if (ls) begin
                wbank_m = !wbank_m;
                waddr_m = 0;
            end
            mem_m[wbank_m][waddr_m] = px;
            val_m[wbank_m][waddr_m] = 1;
            if (waddr_m < HLEN - 1) waddr_m++;
            hs_l_m  = hs;
            last_ls = ls;
        end
        last_p2 = p2c;
    endtask

    initial begin
        logic [11:0] px;
        tbl[0] = '{396, -1, 0, -1, -1};
        tbl[1] = '{396, -1, 0,  2, 32};
        tbl[2] = '{396, -1, 0,  2, 32};
        tbl[3] = '{300, -1, 0,  2, 32};
        tbl[4] = '{396,  5, 0, -1, -1};
        tbl[5] = '{396, -1, 0,  2, 32};
        tbl[6] = '{420, -1, 0,  3, 32};
        tbl[7] = '{396, -1, 1,  2, 32};
        tbl[8] = '{396, -1, 0,  2, 32};

        for (int b = 0; b < 2; b++)
            for (int a = 0; a < HLEN; a++) val_m[b][a] = 0;

        vid.pxl_cen  = 0;
        vid.pxl2_cen = 0;
        vid.base_pxl = '0;
        vid.HS       = 0;

        #50;
        chk("reset_x2_pxl", int'(vid.x2_pxl), 0);
        chk("reset_x2_HS", int'(vid.x2_HS), 0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;

        for (int L = 0; L < NL; L++) begin
            cur_line = L;
            rises = 0;
            wmax  = 0;
            for (int p = 0; p < tbl[L].npix; p++) begin
                if (tbl[L].cpix) begin
                    px = 12'hAAA;
                end else begin
                    px = lfsr;
                    lfsr = {lfsr[10:0], lfsr[4] ^ lfsr[11]};
                end
                if (L == 6 && p == tbl[L].npix - 1) long_last = px;
                for (int s = 0; s < 8; s++) begin
                    step_sample();
                    if (s == 0 && p == tbl[L].rst_at) begin
                        chk("pre_rst_x2_HS", int'(vid.x2_HS), 1);
                        rst_n = 0;
                        #1;
                        chk("rst_x2_pxl", int'(vid.x2_pxl), 0);
                        chk("rst_x2_HS", int'(vid.x2_HS), 0);
                        wbank_m = 0;
                        waddr_m = 0;
                        hs_l_m  = 0;
                        j       = -1;
                        prev_hs = 0;
                        wcur    = 0;
                    end
                    if (s == 0 && tbl[L].rst_at >= 0 && p == tbl[L].rst_at + 1)
                        rst_n = 1;
                    drive(s == 0, s == 0 || s == 4, px, p == 0);
                end
            end
            if (tbl[L].exp_rises >= 0) begin
                chk("hs_rises", rises, tbl[L].exp_rises);
                chk("hs_width", wmax, tbl[L].exp_width);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
